engine_m_axi_read_cmd_gen: RTL and testbench

Per-engine AXI4 read-command generator. It turns one buffer read request (base address plus byte length) into a sequence of AR bursts that respect the 4 KB boundary and a configurable burst cap. It bounds in-flight bursts, counts returning RLAST beats, and walks the `cu_engine_m_axi_state` one-hot state machine. It sits between the engine control logic (upstream) and the CU cache/M_AXI port (downstream).

---
 rtl/engine_m_axi_read_cmd_gen_pkg.sv | 19 +
 rtl/engine_m_axi_read_cmd_gen_outstanding.sv | 41 ++++
 rtl/engine_m_axi_read_cmd_gen.sv | 145 ++++++++++++++
 tb/tb_engine_m_axi_read_cmd_gen.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/engine_m_axi_read_cmd_gen_pkg.sv
// Shared definitions for the engine M_AXI read-command generator.
//   cu_engine_m_axi_state  : one-hot engine state encoding (exactly one bit set)
//   M_AXI4_BOUNDARY_BYTES  : AXI4 bursts must not cross this address boundary
//   M_AXI4_MAX_BURST_BEATS : AXI4 INCR burst length limit (arlen is 8 bits)
package engine_m_axi_read_cmd_gen_pkg;

    localparam int GLOBAL_BUFFER_SIZE_WIDTH_BITS = 32;
    localparam int M_AXI4_BOUNDARY_BYTES         = 4096;
    localparam int M_AXI4_MAX_BURST_BEATS        = 256;

    typedef enum logic [4:0] {
        ENGINE_M_AXI_RESET     = 5'b00001,
        ENGINE_M_AXI_READY     = 5'b00010,
        ENGINE_M_AXI_CMD_TRANS = 5'b00100,
        ENGINE_M_AXI_PEND      = 5'b01000,
        ENGINE_M_AXI_DONE      = 5'b10000
    } cu_engine_m_axi_state;

endpackage

// File: rtl/engine_m_axi_read_cmd_gen_outstanding.sv
// Up/down saturating counter of accepted-but-unfinished AR bursts.
//   clk, rst  : clock, asynchronous active-high reset
//   inc, dec  : burst accepted / burst finished (both at once cancel out)
//   count     : current occupancy, 0..MAX_COUNT
//   full      : count == MAX_COUNT
//   empty     : count == 0
//   underflow : sticky; set when dec arrives alone while empty
module m_axi_outstanding_counter #(
    parameter  int MAX_COUNT = 16,
    localparam int CW        = $clog2(MAX_COUNT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          underflow
);

    assign full  = (count == CW'(MAX_COUNT));
    assign empty = (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            underflow <= 1'b0;
        end else begin
            case ({inc, dec})
                2'b10: if (!full) count <= count + CW'(1);
                2'b01: begin
                    if (empty) underflow <= 1'b1;
                    else       count     <= count - CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/engine_m_axi_read_cmd_gen.sv
// Per-engine AXI4 read-command generator: splits one buffer read request
// (beat-aligned base address + byte length) into AR bursts that respect the
// 4 KB boundary and MAX_BURST_BEATS, bounds in-flight bursts and reports
// completion once every issued burst has returned its RLAST.
//   ap_clk, areset                    : clock, asynchronous active-high reset
//   start_in, base_address_in,
//   length_bytes_in                   : request (sampled only in READY)
//   ready_out, done_out, state_out    : engine status (done_out is a 1-cycle pulse)
//   m_axi_arvalid/arready/araddr/arlen: AR channel
//   rlast_in                          : one pulse per finished read burst
//   error_out                         : sticky, RLAST seen with nothing outstanding
module engine_m_axi_read_cmd_gen
    import engine_m_axi_read_cmd_gen_pkg::*;
#(
    parameter int M_AXI_ADDR_WIDTH       = 64,
    parameter int M_AXI_DATA_WIDTH_BYTES = 64,
    parameter int MAX_BURST_BEATS        = 64,
    parameter int MAX_OUTSTANDING        = 16,
    parameter int LENGTH_WIDTH           = GLOBAL_BUFFER_SIZE_WIDTH_BITS
) (
    input  logic                        ap_clk,
    input  logic                        areset,
    input  logic                        start_in,
    input  logic [M_AXI_ADDR_WIDTH-1:0] base_address_in,
    input  logic [LENGTH_WIDTH-1:0]     length_bytes_in,
    output logic                        ready_out,
    output logic                        done_out,
    output logic [4:0]                  state_out,
    output logic                        m_axi_arvalid,
    input  logic                        m_axi_arready,
    output logic [M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                  m_axi_arlen,
    input  logic                        rlast_in,
    output logic                        error_out
);

    localparam int BEAT_SHIFT = $clog2(M_AXI_DATA_WIDTH_BYTES);
    localparam int LW1        = LENGTH_WIDTH + 1;
    localparam int CW         = $clog2(MAX_OUTSTANDING + 1);

    // Beats of the next burst: limited by what is left, the burst cap and
    // the distance to the next 4 KB page.
    function automatic logic [8:0] burst_beats(input logic [11:0] page_off,
                                               input logic [LW1-1:0] left);
        logic [12:0]    to_boundary;
        logic [LW1-1:0] beats;
        to_boundary = (13'(M_AXI4_BOUNDARY_BYTES) - {1'b0, page_off}) >> BEAT_SHIFT;
        beats = left;
        if (beats > LW1'(MAX_BURST_BEATS)) beats = LW1'(MAX_BURST_BEATS);
        if (beats > LW1'(to_boundary))     beats = LW1'(to_boundary);
        return 9'(beats);
    endfunction

    cu_engine_m_axi_state state, state_next;

    // addr/beats_left always describe the next burst not yet presented on AR.
    logic [M_AXI_ADDR_WIDTH-1:0] addr;
    logic [LW1-1:0]              beats_left;
    logic [LW1-1:0]              length_beats;
    logic [8:0]                  beats_this;
    logic [CW-1:0]               outstanding;
    logic                        out_full, out_empty;
    logic                        ar_handshake, load_ok, issue, pend_clear;

    assign length_beats = ({1'b0, length_bytes_in} + LW1'(M_AXI_DATA_WIDTH_BYTES - 1)) >> BEAT_SHIFT;
    assign beats_this   = burst_beats(addr[11:0], beats_left);
    assign ar_handshake = m_axi_arvalid && m_axi_arready;

    // A new burst may be presented only if occupancy after this cycle stays
    // below the limit, accounting for the handshake and rlast of this cycle.
    assign load_ok = ar_handshake ? ((outstanding < CW'(MAX_OUTSTANDING - 1)) || rlast_in)
                                  : (!out_full || rlast_in);
    assign issue   = (state == ENGINE_M_AXI_CMD_TRANS) && (!m_axi_arvalid || ar_handshake) &&
                     (beats_left != '0) && load_ok;

    // The final rlast in PEND moves to DONE on the very next edge.
    assign pend_clear = out_empty || ((outstanding == CW'(1)) && rlast_in);

    m_axi_outstanding_counter #(
        .MAX_COUNT (MAX_OUTSTANDING)
    ) u_outstanding (
        .clk       (ap_clk),
        .rst       (areset),
        .inc       (ar_handshake),
        .dec       (rlast_in),
        .count     (outstanding),
        .full      (out_full),
        .empty     (out_empty),
        .underflow (error_out)
    );

    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) state <= ENGINE_M_AXI_RESET;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ENGINE_M_AXI_RESET: state_next = ENGINE_M_AXI_READY;
            ENGINE_M_AXI_READY: begin
                if (start_in)
                    state_next = (length_beats == '0) ? ENGINE_M_AXI_DONE : ENGINE_M_AXI_CMD_TRANS;
            end
            ENGINE_M_AXI_CMD_TRANS: begin
                if (ar_handshake && (beats_left == '0)) state_next = ENGINE_M_AXI_PEND;
            end
            ENGINE_M_AXI_PEND: begin
                if (pend_clear) state_next = ENGINE_M_AXI_DONE;
            end
            ENGINE_M_AXI_DONE: state_next = ENGINE_M_AXI_READY;
            default:           state_next = ENGINE_M_AXI_RESET;
        endcase
    end

    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            addr          <= '0;
            beats_left    <= '0;
            m_axi_araddr  <= '0;
            m_axi_arlen   <= '0;
            m_axi_arvalid <= 1'b0;
        end else begin
            if ((state == ENGINE_M_AXI_READY) && start_in) begin
                addr       <= base_address_in;
                beats_left <= length_beats;
            end
            if (issue) begin
                m_axi_araddr  <= addr;
                m_axi_arlen   <= 8'(beats_this - 9'd1);
                m_axi_arvalid <= 1'b1;
                addr          <= addr + (M_AXI_ADDR_WIDTH'(beats_this) << BEAT_SHIFT);
                beats_left    <= beats_left - LW1'(beats_this);
            end else if (ar_handshake) begin
                m_axi_arvalid <= 1'b0;
            end
        end
    end

    // Status outputs decode the one-hot state register directly.
    assign state_out = state;
    assign ready_out = (state == ENGINE_M_AXI_READY);
    assign done_out  = (state == ENGINE_M_AXI_DONE);

endmodule

// File: tb/tb_engine_m_axi_read_cmd_gen.sv
// Scoreboard bench for engine_m_axi_read_cmd_gen (MAX_OUTSTANDING = 2).
module tb_engine_m_axi_read_cmd_gen;

    localparam logic [4:0] ST_RESET = 5'b00001;
    localparam logic [4:0] ST_READY = 5'b00010;
    localparam logic [4:0] ST_CMD   = 5'b00100;
    localparam logic [4:0] ST_PEND  = 5'b01000;
    localparam logic [4:0] ST_DONE  = 5'b10000;

    logic        ap_clk = 1'b0;
    logic        areset = 1'b1;
    logic        start_in = 1'b0;
    logic [63:0] base_address_in = '0;
    logic [31:0] length_bytes_in = '0;
    logic        ready_out, done_out, error_out;
    logic [4:0]  state_out;
    logic        m_axi_arvalid;
    logic        m_axi_arready = 1'b0;
    logic [63:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic        rlast_in = 1'b0;

    engine_m_axi_read_cmd_gen #(
        .M_AXI_ADDR_WIDTH       (64),
        .M_AXI_DATA_WIDTH_BYTES (64),
        .MAX_BURST_BEATS        (64),
        .MAX_OUTSTANDING        (2),
        .LENGTH_WIDTH           (32)
    ) dut (
        .ap_clk          (ap_clk),
        .areset          (areset),
        .start_in        (start_in),
        .base_address_in (base_address_in),
        .length_bytes_in (length_bytes_in),
        .ready_out       (ready_out),
        .done_out        (done_out),
        .state_out       (state_out),
        .m_axi_arvalid   (m_axi_arvalid),
        .m_axi_arready   (m_axi_arready),
        .m_axi_araddr    (m_axi_araddr),
        .m_axi_arlen     (m_axi_arlen),
        .rlast_in        (rlast_in),
        .error_out       (error_out)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  len;
    } ar_t;

    ar_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  hs_count = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops an expected burst on every AR handshake and checks that a
    // stalled burst keeps valid, address and length unchanged.
    logic        stall_p = 1'b0;
    logic [63:0] stall_addr = '0;
    logic [7:0]  stall_len = '0;

    always @(negedge ap_clk) begin
        if (areset) begin
            stall_p = 1'b0;
        end else begin
            if (stall_p) begin
                chk("ar_hold_valid", 64'(m_axi_arvalid), 64'd1);
                chk("ar_hold_addr", m_axi_araddr, stall_addr);
                chk("ar_hold_len", 64'(m_axi_arlen), 64'(stall_len));
            end
            if (m_axi_arvalid && m_axi_arready) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL ar_unexpected actual=addr 0x%0h len %0d expected=no burst",
                             m_axi_araddr, m_axi_arlen);
                end else begin
                    ar_t e;
                    e = exp_q.pop_front();
                    chk("ar_addr", m_axi_araddr, e.addr);
                    chk("ar_len", 64'(m_axi_arlen), 64'(e.len));
                end
            end
            stall_p    = m_axi_arvalid && !m_axi_arready;
            stall_addr = m_axi_araddr;
            stall_len  = m_axi_arlen;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge ap_clk);
        #1;
    endtask

    task automatic do_start(input logic [63:0] base, input logic [31:0] len);
        base_address_in = base;
        length_bytes_in = len;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
    endtask

    task automatic pulse_rlast();
        rlast_in = 1'b1;
        tick();
        rlast_in = 1'b0;
    endtask

    task automatic wait_state(input logic [4:0] st, input int budget, input string name);
        int k;
        k = 0;
        while (state_out !== st && k < budget) begin
            tick();
            k++;
        end
        chk(name, 64'(state_out), 64'(st));
    endtask

    initial begin
        int h0;
        tick(3);
        chk("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
        chk("rst_araddr", m_axi_araddr, 64'd0);
        chk("rst_arlen", 64'(m_axi_arlen), 64'd0);
        chk("rst_done", 64'(done_out), 64'd0);
        chk("rst_error", 64'(error_out), 64'd0);
        chk("rst_ready", 64'(ready_out), 64'd0);
        chk("rst_state", 64'(state_out), 64'(ST_RESET));
        areset = 1'b0;
        tick();
        chk("rst_to_ready", 64'(ready_out), 64'd1);
        chk("rst_ready_state", 64'(state_out), 64'(ST_READY));

        // Short non-multiple length: 100 bytes -> 2 beats
        m_axi_arready = 1'b1;
        exp_q.push_back('{addr: 64'h1000, len: 8'd1});
        do_start(64'h1000, 32'd100);
        chk("t1_cmd_state", 64'(state_out), 64'(ST_CMD));
        chk("t1_ready_low", 64'(ready_out), 64'd0);
        chk("t1_no_early_valid", 64'(m_axi_arvalid), 64'd0);
        tick();
        chk("t1_arvalid", 64'(m_axi_arvalid), 64'd1);
        tick();
        chk("t1_pend", 64'(state_out), 64'(ST_PEND));
        chk("t1_arvalid_low", 64'(m_axi_arvalid), 64'd0);
        pulse_rlast();
        chk("t1_done", 64'(done_out), 64'd1);
        chk("t1_done_state", 64'(state_out), 64'(ST_DONE));
        tick();
        chk("t1_done_pulse", 64'(done_out), 64'd0);
        chk("t1_back_ready", 64'(ready_out), 64'd1);

        // Burst cap split: 8192 bytes -> two 64-beat bursts back to back
        exp_q.push_back('{addr: 64'h0, len: 8'd63});
        exp_q.push_back('{addr: 64'h1000, len: 8'd63});
        do_start(64'h0, 32'd8192);
        tick();
        chk("t2_b0_valid", 64'(m_axi_arvalid), 64'd1);
        chk("t2_b0_addr", m_axi_araddr, 64'h0);
        tick();
        chk("t2_b1_valid", 64'(m_axi_arvalid), 64'd1);
        chk("t2_b1_addr", m_axi_araddr, 64'h1000);
        tick();
        chk("t2_pend", 64'(state_out), 64'(ST_PEND));
        pulse_rlast();
        chk("t2_no_early_done", 64'(done_out), 64'd0);
        pulse_rlast();
        chk("t2_done", 64'(done_out), 64'd1);
        tick();

        // 4 KB crossing: 0xFC0 + 256 bytes -> 1 beat then 3 beats
        exp_q.push_back('{addr: 64'h0FC0, len: 8'd0});
        exp_q.push_back('{addr: 64'h1000, len: 8'd2});
        do_start(64'h0FC0, 32'd256);
        wait_state(ST_PEND, 10, "t3_pend");
        chk("t3_bursts", 64'(exp_q.size()), 64'd0);
        pulse_rlast();
        pulse_rlast();
        chk("t3_done", 64'(done_out), 64'd1);
        tick();

        // Outstanding limit (2) and backpressure: 16384 bytes -> 4 bursts
        exp_q.push_back('{addr: 64'h2000, len: 8'd63});
        exp_q.push_back('{addr: 64'h3000, len: 8'd63});
        exp_q.push_back('{addr: 64'h4000, len: 8'd63});
        exp_q.push_back('{addr: 64'h5000, len: 8'd63});
        h0 = hs_count;
        do_start(64'h2000, 32'd16384);
        tick(8);
        chk("t4_limit_count", 64'(hs_count - h0), 64'd2);
        chk("t4_limit_valid_low", 64'(m_axi_arvalid), 64'd0);
        chk("t4_limit_state", 64'(state_out), 64'(ST_CMD));
        pulse_rlast();
        tick(4);
        chk("t4_release_count", 64'(hs_count - h0), 64'd3);
        chk("t4_release_valid_low", 64'(m_axi_arvalid), 64'd0);
        m_axi_arready = 1'b0;
        pulse_rlast();
        tick(5);
        chk("t4_stall_valid", 64'(m_axi_arvalid), 64'd1);
        chk("t4_stall_addr", m_axi_araddr, 64'h5000);
        chk("t4_stall_len", 64'(m_axi_arlen), 64'd63);
        chk("t4_stall_count", 64'(hs_count - h0), 64'd3);
        m_axi_arready = 1'b1;
        tick();
        chk("t4_final_count", 64'(hs_count - h0), 64'd4);
        chk("t4_pend", 64'(state_out), 64'(ST_PEND));
        pulse_rlast();
        pulse_rlast();
        chk("t4_done", 64'(done_out), 64'd1);
        tick();

        // Zero length
        do_start(64'h3000, 32'd0);
        chk("t5_done_state", 64'(state_out), 64'(ST_DONE));
        chk("t5_done", 64'(done_out), 64'd1);
        chk("t5_no_valid", 64'(m_axi_arvalid), 64'd0);
        tick();
        chk("t5_ready", 64'(ready_out), 64'd1);
        chk("t5_done_pulse", 64'(done_out), 64'd0);

        // Stray rlast while idle
        chk("t5_error_clear", 64'(error_out), 64'd0);
        pulse_rlast();
        chk("t5_error_set", 64'(error_out), 64'd1);
        tick(3);
        chk("t5_error_sticky", 64'(error_out), 64'd1);
        chk("t5_still_ready", 64'(ready_out), 64'd1);

        // Reset while a burst is stalled on AR
        m_axi_arready = 1'b0;
        do_start(64'h0, 32'd8192);
        tick();
        chk("t6_arvalid_up", 64'(m_axi_arvalid), 64'd1);
        tick(2);
        areset = 1'b1;
        #1;
        chk("t6_arvalid_drop", 64'(m_axi_arvalid), 64'd0);
        chk("t6_state_reset", 64'(state_out), 64'(ST_RESET));
        chk("t6_error_clear", 64'(error_out), 64'd0);
        chk("t6_araddr_clear", m_axi_araddr, 64'd0);
        tick(2);
        areset = 1'b0;
        tick();
        chk("t6_ready", 64'(ready_out), 64'd1);
        chk("t6_ready_state", 64'(state_out), 64'(ST_READY));

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
